mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single 32-bit CPU-side memory port (15-bit word address, 32-bit data, write strobe, read-start / read-ready / save-ready handshake) among three requesters: port 0 = CPU core, port 1 = DMA, port 2 = video fetch.
- Sits between the requesters and the RAM/ROM address decoder; that decoder is unchanged.
- Each requester issues a one-cycle request pulse with its payload. The arbiter queues the request, serialises transactions, runs the memory handshake, and returns data plus a one-cycle acknowledge.

Parameters:
- NPORT, 3, number of requesters; fixed at 3 in this revision (the round-robin order is hard-coded).
- TIMEOUT, 255, WAIT-state cycles allowed before a transaction is aborted; 8-bit counter; must be at least 1.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- req  input  3  per-port request pulse, one cycle; bit i = port i.
- req_we  input  3  per-port write flag, sampled with req[i].
- req_addr  input  45  per-port word address; port i uses bits [15i+14:15i].
- req_wdata  input  96  per-port write data; port i uses bits [32i+31:32i].
- busy  output  3  bit i is high from the cycle after req[i] is accepted until the cycle ack[i] is high, inclusive.
- ack  output  3  one-cycle completion pulse per port.
- err  output  1  valid with ack; 1 = transaction timed out.
- rdata  output  32  read data; valid with ack; holds its value until the next ack.
- mem_addr  output  15  address to the decoder.
- mem_wdata  output  32  write data to the decoder.
- mem_w  output  1  one-cycle write strobe.
- mem_start  output  1  one-cycle read-start strobe.
- mem_rdata  input  32  read data from memory.
- mem_readrdy  input  1  read complete.
- mem_saverdy  input  1  write complete.
- grant_id  output  2  port currently being served; 3 = none.

Behaviour:
- Reset values:
  - All outputs 0, except grant_id = 3.
  - Pending bits, payload latches, state register and timeout counter = 0.
  - Round-robin pointer last = 2, so port 0 has first priority after reset.
- Request capture:
  - req[i] while busy[i] = 0: latch we/addr/wdata for port i and set pending[i]; busy[i] rises next cycle.
  - req[i] while busy[i] = 1: ignored; payload and pending unchanged.
- State machine (registered state):
  - IDLE: if any pending, select the winner using the priority order last+1, last+2, last (mod 3). Load mem_addr/mem_wdata from the winner's latch, set grant_id and last, clear pending[winner], go to ISSUE.
  - ISSUE: one cycle. mem_w = 1 if the latched we is set, else mem_start = 1. Timeout counter cleared. Go to WAIT.
  - WAIT:
    - Write completes on mem_saverdy; read completes on mem_readrdy, which also captures rdata <= mem_rdata.
    - The ready input for the other direction is ignored.
    - If neither arrives within TIMEOUT WAIT cycles: rdata <= 0, err <= 1.
    - Go to DONE on completion or timeout.
  - DONE: ack[grant_id] = 1 and err valid for this cycle; busy[grant_id] drops next cycle; grant_id <= 3; go to IDLE.
- mem_addr and mem_wdata are held stable from ISSUE through DONE; both are 0 in IDLE.
- Minimum latency from req pulse at cycle 0 with memory ready in the first WAIT cycle:
  - capture at cycle 0, IDLE/select at 1, ISSUE at 2, WAIT at 3 (ready sampled), ack at cycle 4.
- Back-to-back: after DONE, IDLE takes one cycle before the next ISSUE; no transaction overlaps another.
- Simultaneous events:
  - A new req on the port being served is ignored until its ack cycle has passed; busy stays 1 through ack.
  - req on other ports during any state is captured normally.
- Ready pulses arriving outside WAIT are ignored.
- rst asserted mid-transaction: immediate return to IDLE. All pending requests are lost and no ack is issued; requesters must re-issue.

Optional Feature:
- Macro: MEM_ARB_CPU_PRIO_EN.
- Defined: port 0 has fixed highest priority; ports 1 and 2 round-robin between themselves only when port 0 is not pending. last is updated only on grants to port 1 or 2.
- Undefined: plain three-way round-robin as described above.

Test Plan:
- Single read: port 0 req, addr 0x0123; memory returns 0xDEADBEEF with mem_readrdy on the first WAIT cycle -> mem_start one pulse at cycle 2, ack = 3'b001 at cycle 4, rdata = 0xDEADBEEF, err = 0.
- Write: port 1 req_we = 1, addr 0x1800, wdata 0xA5A5_0F0F; mem_saverdy three cycles after ISSUE -> mem_w one pulse with mem_addr = 0x1800 and mem_wdata = 0xA5A50F0F; ack = 3'b010; mem_start never asserted.
- Contention: all three ports request in the same cycle after reset, memory always ready -> grant order 0, 1, 2 and acks 4 cycles apart. Repeat the burst -> order 0, 1, 2 again; with MEM_ARB_CPU_PRIO_EN and port 0 re-requesting each time -> 0, 1, 0, 2.
- Timeout: TIMEOUT = 4, read with no mem_readrdy -> ack after 4 WAIT cycles with err = 1 and rdata = 0; the next transaction completes normally with err = 0.
- Duplicate request: port 2 req, then a second req on port 2 while busy[2] = 1 with a different addr -> exactly one transaction, using the first addr.
- Reset mid-WAIT: drop rst during WAIT -> grant_id = 3, busy = 0, no ack; after release a new req completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises three requesters onto the shared 32-bit memory port.
// Build option MEM_ARB_CPU_PRIO_EN gives port 0 fixed priority over a 1/2 round-robin.
module mem_port_arbiter #(
    parameter int NPORT   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NPORT-1:0]      req,
    input  logic [NPORT-1:0]      req_we,
    input  logic [15*NPORT-1:0]   req_addr,
    input  logic [32*NPORT-1:0]   req_wdata,
    output logic [NPORT-1:0]      busy,
    output logic [NPORT-1:0]      ack,
    output logic                  err,
    output logic [31:0]           rdata,
    output logic [14:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_w,
    output logic                  mem_start,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_readrdy,
    input  logic                  mem_saverdy,
    output logic [1:0]            grant_id
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state, state_nx;
    logic [NPORT-1:0] pending, lat_we;
    logic [14:0] lat_addr [NPORT];
    logic [31:0] lat_wdata [NPORT];
    logic [1:0] last, win, nx1, nx2;
    logic cur_we, err_q, rdy, tmo;
    logic [7:0] cnt;
    assign nx1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
    assign nx2 = (nx1 == 2'd2) ? 2'd0 : nx1 + 2'd1;
`ifdef MEM_ARB_CPU_PRIO_EN
    assign win = pending[0] ? 2'd0 :
                 (last == 2'd1) ? (pending[2] ? 2'd2 : 2'd1) : (pending[1] ? 2'd1 : 2'd2);
`else
    assign win = pending[nx1] ? nx1 : pending[nx2] ? nx2 : last;
`endif
    // only the ready of the transaction's own direction can complete it
    assign rdy = cur_we ? mem_saverdy : mem_readrdy;
    assign tmo = cnt == 8'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = (state == IDLE)  ? (|pending ? ISSUE : IDLE) :
                   (state == ISSUE) ? WAIT :
                   (state == WAIT)  ? ((rdy || tmo) ? DONE : WAIT) : IDLE;
    end
    always_comb begin
        mem_w     = state == ISSUE && cur_we;
        mem_start = state == ISSUE && !cur_we;
        ack       = (state == DONE) ? NPORT'(1) << grant_id : '0;
        err       = state == DONE && err_q;
        busy      = pending | ((state != IDLE) ? NPORT'(1) << grant_id : '0);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending   <= '0;
            lat_we    <= '0;
            last      <= 2'd2;
            grant_id  <= 2'd3;
            cur_we    <= 1'b0;
            err_q     <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cnt       <= '0;
            for (int i = 0; i < NPORT; i++) begin
                lat_addr[i]  <= '0;
                lat_wdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NPORT; i++)
                if (req[i] && !busy[i]) begin
                    pending[i]   <= 1'b1;
                    lat_we[i]    <= req_we[i];
                    lat_addr[i]  <= req_addr[15*i +: 15];
                    lat_wdata[i] <= req_wdata[32*i +: 32];
                end
            // the winner is busy, so the capture loop above never touches its bit
            if (state == IDLE && |pending) begin
                pending[win] <= 1'b0;
                grant_id     <= win;
                cur_we       <= lat_we[win];
                mem_addr     <= lat_addr[win];
                mem_wdata    <= lat_wdata[win];
`ifdef MEM_ARB_CPU_PRIO_EN
                if (win != 2'd0) last <= win;
`else
                last <= win;
`endif
            end
            if (state == ISSUE) cnt <= '0;
            if (state == WAIT) begin
                cnt <= cnt + 8'd1;
                if (rdy) begin
                    err_q <= 1'b0;
                    if (!cur_we) rdata <= mem_rdata;
                end else if (tmo) begin
                    err_q <= 1'b1;
                    rdata <= '0;
                end
            end
            if (state == DONE) begin
                grant_id  <= 2'd3;
                mem_addr  <= '0;
                mem_wdata <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int TO = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic [2:0] req, req_we, busy, ack;
    logic [44:0] req_addr;
    logic [95:0] req_wdata;
    logic err, mem_w, mem_start, mem_readrdy, mem_saverdy;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [14:0] mem_addr;
    logic [1:0] grant_id;

    mem_port_arbiter #(.NPORT(3), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .ack(ack), .err(err), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w(mem_w), .mem_start(mem_start),
        .mem_rdata(mem_rdata), .mem_readrdy(mem_readrdy), .mem_saverdy(mem_saverdy),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int total, bad;
    int n, cur, t_iss, t_ack, dly, m_last, force_d, n_w, n_start;
    bit noise, fix_rd;
    logic [2:0] m_pend;
    logic m_we [3];
    logic [14:0] m_addr [3];
    logic [31:0] m_wd [3];
    logic c_we, m_err, last_err;
    logic [14:0] c_addr;
    logic [31:0] c_wd, m_rdata, last_rdata;
    int acks_q[$], ack_cyc[$], iss_cyc[$];
    logic [14:0] addr_q[$];
    logic [2:0] rr, rw;
    logic [44:0] ra;
    logic [95:0] rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // arbitration decision taken straight from the priority rules
    function automatic int pick();
`ifdef MEM_ARB_CPU_PRIO_EN
        if (m_pend[0]) return 0;
        if (m_pend[1] && m_pend[2]) return (m_last == 1) ? 2 : 1;
        return m_pend[1] ? 1 : 2;
`else
        for (int k = 1; k <= 3; k++)
            if (m_pend[(m_last + k) % 3]) return (m_last + k) % 3;
        return 0;
`endif
    endfunction

    task automatic check_cycle();
        logic act;
        act = cur >= 0;
        chk("busy", busy, m_pend | (act ? 3'b001 << cur : 3'b000));
        chk("grant_id", grant_id, act ? 2'(cur) : 2'd3);
        chk("mem_addr", mem_addr, act ? c_addr : 15'd0);
        chk("mem_wdata", mem_wdata, act ? c_wd : 32'd0);
        chk("mem_w", mem_w, act && n == t_iss && c_we);
        chk("mem_start", mem_start, act && n == t_iss && !c_we);
        chk("ack", ack, (act && n == t_ack) ? 3'b001 << cur : 3'b000);
        chk("err", err, act && n == t_ack && m_err);
        chk("rdata", rdata, m_rdata);
        if (ack != 3'b000) begin
            acks_q.push_back(int'(grant_id));
            ack_cyc.push_back(n);
            last_err = err;
            last_rdata = rdata;
        end
        if (mem_w || mem_start) begin
            addr_q.push_back(mem_addr);
            iss_cyc.push_back(n);
        end
        n_w += int'(mem_w);
        n_start += int'(mem_start);
    endtask

    task automatic cyc(input logic [2:0] r, input logic [2:0] we, input logic [44:0] a, input logic [95:0] wd);
        logic act, in_wait, hit;
        logic [2:0] bz;
        int w;
        act = cur >= 0;
        bz = m_pend | (act ? 3'b001 << cur : 3'b000);
        in_wait = act && n > t_iss && n < t_ack;
        hit = in_wait && dly < TO && n == t_iss + 1 + dly;
        req = r; req_we = we; req_addr = a; req_wdata = wd;
        mem_rdata = fix_rd ? 32'hDEADBEEF : $urandom;
        mem_readrdy = noise && ($urandom_range(0, 3) == 0);
        mem_saverdy = noise && ($urandom_range(0, 3) == 0);
        if (in_wait) begin
            if (c_we) mem_saverdy = hit;
            else mem_readrdy = hit;
        end
        if (hit && !c_we) m_rdata = mem_rdata;
        if (in_wait && dly >= TO && n == t_ack - 1) m_rdata = '0;
        if (act && n == t_ack) cur = -1;
        else if (!act && m_pend != 3'b000) begin
            w = pick();
            cur = w;
            t_iss = n + 1;
            dly = (force_d >= 0) ? force_d : int'($urandom_range(0, TO + 1));
            t_ack = t_iss + 2 + ((dly < TO) ? dly : TO - 1);
            m_err = dly >= TO;
            c_we = m_we[w]; c_addr = m_addr[w]; c_wd = m_wd[w];
            m_pend[w] = 1'b0;
`ifdef MEM_ARB_CPU_PRIO_EN
            if (w != 0) m_last = w;
`else
            m_last = w;
`endif
        end
        for (int i = 0; i < 3; i++)
            if (r[i] && !bz[i]) begin
                m_pend[i] = 1'b1;
                m_we[i] = we[i];
                m_addr[i] = a[15*i +: 15];
                m_wd[i] = wd[32*i +: 32];
            end
        @(posedge clk);
        #1;
        n++;
        check_cycle();
    endtask

    task automatic idle(input int k);
        repeat (k) cyc(3'b000, 3'b000, '0, '0);
    endtask

    task automatic do_reset();
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        mem_readrdy = 1'b0; mem_saverdy = 1'b0; mem_rdata = '0;
        rst = 1'b0;
        #1;
        chk("rst_grant", grant_id, 2'd3);
        chk("rst_busy", busy, 3'b000);
        chk("rst_ack", ack, 3'b000);
        chk("rst_err", err, 1'b0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_addr", mem_addr, 15'd0);
        chk("rst_strobes", {mem_w, mem_start}, 2'b00);
        cur = -1; m_pend = '0; m_last = 2; m_rdata = '0; m_err = 1'b0;
        t_iss = -10; t_ack = -10; n = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic check_order(input string tag, input int e0, input int e1, input int e2, input int e3, input int k);
        int e [4];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < k; i++)
            chk(tag, (i < acks_q.size()) ? acks_q[i] : -1, e[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; n_w = 0; n_start = 0;
        force_d = 0; noise = 0; fix_rd = 1;
        #2;
        do_reset();
        // single read: strobe at cycle 2, ack at cycle 4
        cyc(3'b001, 3'b000, {30'd0, 15'h0123}, '0);
        cyc(3'b000, 3'b000, '0, '0);
        chk("rd_start_c2", mem_start, 1'b1);
        chk("rd_addr_c2", mem_addr, 15'h0123);
        idle(2);
        chk("rd_ack_c4", ack, 3'b001);
        chk("rd_data", rdata, 32'hDEADBEEF);
        chk("rd_err", err, 1'b0);
        idle(2);
        // write with saverdy three cycles after ISSUE
        n_w = 0; n_start = 0; addr_q.delete(); acks_q.delete();
        force_d = 2; fix_rd = 0;
        cyc(3'b010, 3'b010, {15'd0, 15'h1800, 15'd0}, {32'd0, 32'hA5A50F0F, 32'd0});
        idle(8);
        chk("wr_w_count", n_w, 1);
        chk("wr_start_count", n_start, 0);
        chk("wr_addr", (addr_q.size() > 0) ? addr_q[0] : 15'h7FFF, 15'h1800);
        chk("wr_ack_port", (acks_q.size() == 1) ? acks_q[0] : -1, 1);
        // contention bursts
        do_reset();
        force_d = 0;
        acks_q.delete(); ack_cyc.delete();
        cyc(3'b111, 3'b000, {15'h0300, 15'h0200, 15'h0100}, {3{32'h1234_5678}});
        idle(14);
        check_order("burst1_order", 0, 1, 2, 0, 3);
        chk("burst1_gap01", (ack_cyc.size() == 3) ? ack_cyc[1] - ack_cyc[0] : -1, 4);
        chk("burst1_gap12", (ack_cyc.size() == 3) ? ack_cyc[2] - ack_cyc[1] : -1, 4);
        acks_q.delete();
        cyc(3'b111, 3'b000, {15'h0301, 15'h0201, 15'h0101}, '0);
        idle(14);
        check_order("burst2_order", 0, 1, 2, 0, 3);
        acks_q.delete();
        for (int k = 0; k < 18; k++)
            cyc((k == 0) ? 3'b111 : 3'b001, 3'b000, {15'h0302, 15'h0202, 15'h0102}, '0);
        idle(8);
`ifdef MEM_ARB_CPU_PRIO_EN
        check_order("burst3_order", 0, 1, 0, 2, 4);
`else
        check_order("burst3_order", 0, 1, 2, 0, 4);
`endif
        // timeout after a successful read, then a normal transaction
        do_reset();
        fix_rd = 1; force_d = 0;
        cyc(3'b001, 3'b000, {30'd0, 15'h0055}, '0);
        idle(5);
        chk("pre_tmo_rdata", rdata, 32'hDEADBEEF);
        force_d = TO + 1; iss_cyc.delete(); ack_cyc.delete();
        cyc(3'b001, 3'b000, {30'd0, 15'h0056}, '0);
        idle(TO + 4);
        chk("tmo_err", last_err, 1'b1);
        chk("tmo_rdata", last_rdata, 32'd0);
        chk("tmo_latency", (ack_cyc.size() == 1 && iss_cyc.size() == 1) ? ack_cyc[0] - iss_cyc[0] : -1, TO + 1);
        force_d = 1; fix_rd = 0;
        cyc(3'b010, 3'b000, {15'd0, 15'h0777, 15'd0}, '0);
        idle(7);
        chk("post_tmo_err", last_err, 1'b0);
        // duplicate request on a busy port
        do_reset();
        force_d = 0; acks_q.delete(); addr_q.delete();
        cyc(3'b100, 3'b000, {15'h2AAA, 30'd0}, '0);
        repeat (4) cyc(3'b100, 3'b000, {15'h1555, 30'd0}, '0);
        idle(6);
        chk("dup_acks", acks_q.size(), 1);
        chk("dup_addr", (addr_q.size() == 1) ? addr_q[0] : 15'h7FFF, 15'h2AAA);
        // reset while waiting on memory
        do_reset();
        force_d = TO + 1; acks_q.delete();
        cyc(3'b010, 3'b000, {15'd0, 15'h0444, 15'd0}, '0);
        idle(2);
        chk("pre_rst_grant", grant_id, 2'd1);
        do_reset();
        idle(8);
        chk("rst_no_ack", acks_q.size(), 0);
        force_d = 1;
        cyc(3'b010, 3'b010, {15'd0, 15'h0445, 15'd0}, {32'd0, 32'hCAFE_F00D, 32'd0});
        idle(6);
        chk("post_rst_ack", acks_q.size(), 1);
        // random traffic with stray ready pulses
        noise = 1; force_d = -1; fix_rd = 0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 3; i++) begin
                rr[i] = $urandom_range(0, 3) == 0;
                rw[i] = $urandom_range(0, 1) == 1;
                ra[15*i +: 15] = 15'($urandom);
                rd[32*i +: 32] = $urandom;
            end
            cyc(rr, rw, ra, rd);
        end
        noise = 0;
        idle(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
